// File: rtl/ecpri_ram_pkg.sv
// Purpose : shared defaults and word type for the eCPRI payload/scratch RAM.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ecpri_ram_pkg;

  localparam int ECPRI_ADDR_WIDTH = 16;
  localparam int ECPRI_DATA_WIDTH = 8;
  localparam int ECPRI_DEPTH      = 16;

  typedef logic [ECPRI_DATA_WIDTH-1:0] word_t;

endpackage : ecpri_ram_pkg

// File: rtl/ecpri_ram_array.sv
// Purpose : storage array with async clear, synchronous write port and registered read port.
// Latency : write lands at the clock edge; read data appears in rd_dat one edge after the address.
// Backpressure: none; out-of-range writes are dropped and out-of-range reads load zero.
//
// Ports:
//   clk, rst_n     clock and async active-low clear of every word and the read register
//   addr           word address (full width; upper bits take part in the range check)
//   wr_en / wr_dat write strobe and the word to store
//   rd_en          load the read register from addr on this edge
//   rd_dat         registered read word
module ecpri_ram_array
  import ecpri_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ECPRI_ADDR_WIDTH,
  parameter int DATA_WIDTH = ECPRI_DATA_WIDTH,
  parameter int DEPTH      = ECPRI_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  // Compare the whole address against DEPTH so high addresses never alias
  // onto low words through the truncated index.
  assign in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (wr_en && in_range) begin
        mem[idx] <= wr_dat;
      end
      if (rd_en) begin
        rd_q <= in_range ? mem[idx] : '0;
      end
    end
  end

  assign rd_dat = rd_q;

endmodule : ecpri_ram_array

// File: rtl/ecpri_ram.sv
// Purpose : single-port SRAM-style RAM (cs/we/oe) on a shared bidirectional data bus.
// Latency : writes take effect at the edge; reads show on the bus one edge after the address.
// Backpressure: none; the bus is released (high-Z) unless cs & oe & !we outside reset.
//
// Ports:
//   clk, rst_n   clock and async active-low reset (reset also releases the bus)
//   addr         word address
//   data         bidirectional bus: write data in when cs&we, read data out when cs&oe&!we
//   cs, we, oe   chip select, write enable, output enable (all active high)
module ecpri_ram
  import ecpri_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ECPRI_ADDR_WIDTH,
  parameter int DATA_WIDTH = ECPRI_DATA_WIDTH,
  parameter int DEPTH      = ECPRI_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  logic                  wr_en;
  logic                  rd_en;
  logic                  bus_en;
  logic [DATA_WIDTH-1:0] rd_dat;

  assign wr_en  = cs & we;
  assign rd_en  = cs & ~we;
  // we=1 keeps the driver off even with oe=1 so the writer never sees contention;
  // rst_n gates it so an asserted reset releases the bus immediately.
  assign bus_en = rst_n & cs & oe & ~we;

  ecpri_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .wr_en  (wr_en),
    .wr_dat (data),
    .rd_en  (rd_en),
    .rd_dat (rd_dat)
  );

  assign data = bus_en ? rd_dat : 'z;

endmodule : ecpri_ram

// File: tb/tb_ecpri_ram.sv
// Purpose : self-checking bench for ecpri_ram with a behavioural memory model.
// Latency : expects read data one edge after the address.
// Backpressure: n/a; an undriven bus reads as all ones through the pull-up net.
module tb_ecpri_ram;
  import ecpri_ram_pkg::*;

  localparam int DEPTH = ECPRI_DEPTH;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        cs;
  logic        we;
  logic        oe;
  logic        tb_drv;
  word_t       tb_dat;
  tri1  [7:0]  data;

  int errors;
  int checks;

  // Behavioural model: the stored words and the last word captured by a read.
  word_t ref_mem [DEPTH];
  word_t ref_rdq;

  assign data = tb_drv ? tb_dat : 'z;

  ecpri_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .data  (data),
    .cs    (cs),
    .we    (we),
    .oe    (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t ref_read(input logic [15:0] a);
    return (int'(a) < DEPTH) ? ref_mem[a[3:0]] : 8'h00;
  endfunction

  // Bus value the outside world should observe right now.
  function automatic word_t exp_bus();
    if (tb_drv) return tb_dat;
    if (rst_n && cs && oe && !we) return ref_rdq;
    return 8'hFF;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_rdq = 8'h00;
  endtask

  // One clock: apply the model's view of the edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (cs && we) begin
      if (int'(addr) < DEPTH) ref_mem[addr[3:0]] = data;
    end else if (cs) begin
      ref_rdq = ref_read(addr);
    end
    #1;
  endtask

  task automatic set_bus(input logic c, input logic w, input logic o,
                         input logic [15:0] a, input logic drv, input word_t d);
    cs = c; we = w; oe = o; addr = a; tb_drv = drv; tb_dat = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h00);
    model_clear();
    tick();
    set_bus(1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL reset_bus_released: got %h want FF (undriven)", data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_bus(1'b1, 1'b0, 1'b1, 16'(i), 1'b0, 8'h00);
      tick();
      checks++;
      if (data !== 8'h00) begin
        errors++;
        $display("FAIL reset_read addr=%0d: got %h want 00", i, data);
      end
    end
  endtask

  task automatic test_write_read();
    word_t pat [10];
    pat = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
    for (int i = 0; i < 10; i++) begin
      set_bus(1'b1, 1'b1, 1'b0, 16'(i), 1'b1, pat[i]);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_bus(1'b1, 1'b0, 1'b1, 16'(i), 1'b0, 8'h00);
      if (i > 0) begin
        // Before the edge the bus still shows the previous word: 1-cycle latency.
        #1;
        checks++;
        if (data !== pat[i-1]) begin
          errors++;
          $display("FAIL read_latency addr=%0d: got %h want %h", i, data, pat[i-1]);
        end
      end
      tick();
      checks++;
      if (data !== pat[i]) begin
        errors++;
        $display("FAIL readback addr=%0d: got %h want %h", i, data, pat[i]);
      end
    end
  endtask

  task automatic test_bus_release();
    // Load rd_q with a known non-FF word first.
    set_bus(1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 8'h00);
    tick();
    set_bus(1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL release_cs0: got %h want FF", data);
    end
    set_bus(1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL release_oe0: got %h want FF", data);
    end
    // Write to an out-of-range address with nobody driving: RAM must stay off.
    set_bus(1'b1, 1'b1, 1'b1, 16'd16, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL release_we1_oe1: got %h want FF", data);
    end
    set_bus(1'b1, 1'b1, 1'b1, 16'd9, 1'b1, 8'h3C);
    #1;
    checks++;
    if (data !== 8'h3C) begin
      errors++;
      $display("FAIL writer_owns_bus: got %h want 3C", data);
    end
    tick();
    set_bus(1'b1, 1'b1, 1'b0, 16'd9, 1'b1, 8'h0D);
    tick();
  endtask

  task automatic test_out_of_range();
    set_bus(1'b1, 1'b1, 1'b0, 16'd16, 1'b1, 8'hAA);
    tick();
    set_bus(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 8'hAA);
    tick();
    set_bus(1'b1, 1'b0, 1'b1, 16'd16, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL oor_read16: got %h want 00", data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_bus(1'b1, 1'b0, 1'b1, 16'(i), 1'b0, 8'h00);
      tick();
      checks++;
      if (data !== ref_read(16'(i))) begin
        errors++;
        $display("FAIL oor_no_alias addr=%0d: got %h want %h", i, data, ref_read(16'(i)));
      end
    end
    set_bus(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'h24) begin
      errors++;
      $display("FAIL oor_addr0: got %h want 24", data);
    end
  endtask

  task automatic test_cs_gating();
    set_bus(1'b0, 1'b1, 1'b0, 16'd3, 1'b1, 8'h55);
    tick();
    set_bus(1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'h63) begin
      errors++;
      $display("FAIL cs_gating addr3: got %h want 63", data);
    end
    // cs low must also hold rd_q: re-enable and check it still carries 63 before any edge.
    set_bus(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 8'h00);
    tick();
    set_bus(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 8'h00);
    #1;
    checks++;
    if (data !== 8'h63) begin
      errors++;
      $display("FAIL cs_hold_rdq: got %h want 63", data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        c, w, o;
    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom_range(0, 19));
      if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
      c = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      set_bus(c, w, o, a, w, 8'($urandom_range(0, 255)));
      tick();
      checks++;
      if (data !== exp_bus()) begin
        errors++;
        $display("FAIL random n=%0d cs=%b we=%b oe=%b addr=%h: got %h want %h",
                 n, c, w, o, a, data, exp_bus());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_bus(1'b1, 1'b0, 1'b1, 16'(i), 1'b0, 8'h00);
      tick();
      checks++;
      if (data !== ref_read(16'(i))) begin
        errors++;
        $display("FAIL random_final addr=%0d: got %h want %h", i, data, ref_read(16'(i)));
      end
    end
  endtask

  task automatic test_async_reset();
    set_bus(1'b1, 1'b1, 1'b0, 16'd5, 1'b1, 8'h8D);
    tick();
    set_bus(1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'h8D) begin
      errors++;
      $display("FAIL pre_reset_read: got %h want 8D", data);
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset_release: got %h want FF", data);
    end
    // A write during reset is lost.
    set_bus(1'b1, 1'b1, 1'b0, 16'd5, 1'b1, 8'h77);
    tick();
    rst_n = 1'b1;
    set_bus(1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 8'h00);
    #1;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL rdq_cleared: got %h want 00", data);
    end
    tick();
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_addr5: got %h want 00", data);
    end
    set_bus(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 8'h00);
    tick();
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_addr0: got %h want 00", data);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_read();
    test_bus_release();
    test_out_of_range();
    test_cs_gating();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ecpri_ram
